demux_burst_scheduler: RTL and testbench
========================================

DEMUX_BURST_SCHEDULER -- requirements
Module: demux_burst_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of data path.
REQ-002 Parameter BURST_LEN, default 4, beats per burst before destination may change; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  permits scheduling; sampled only in IDLE and at end of SWITCH.
REQ-006 mode  input  1  0 = round-robin (toggle destination per burst), 1 = forced (destination = force_sel per burst).
REQ-007 force_sel  input  1  requested destination in forced mode.
REQ-008 in_valid  input  1  source beat valid.
REQ-009 in_data  input  DATA_WIDTH  source beat data.
REQ-010 in_ready  output  1  scheduler accepts beat this cycle.
REQ-011 out_ready  input  2  per-destination ready; bit i for destination i.
REQ-012 out_valid  output  2  demultiplexed valid; at most one bit set.
REQ-013 out_data  output  DATA_WIDTH  shared data bus for both destinations.
REQ-014 sel  output  1  destination of the burst currently being accepted.
REQ-015 burst_done  output  1  one-cycle pulse when last beat of a burst is accepted.

Function
REQ-016 Beat accepted when in_valid & in_ready at a rising edge; beat held when not accepted (source keeps in_valid/in_data stable).
REQ-017 One-entry output register holds data and destination tag dest_q; latency input-accept to out_valid = 1 cycle.
REQ-018 out_valid[dest_q] = entry full; out_valid[~dest_q] = 0; out_data = stored data, unchanged while entry full and not drained.
REQ-019 Entry drained when full & out_ready[dest_q]; simultaneous drain and accept in same cycle gives full throughput (1 beat/cycle).
REQ-020 out_ready of the non-addressed destination has no effect.
REQ-021 in_ready = (state == ROUTE) & (entry empty | out_ready[dest_q]).
REQ-022 FSM states IDLE, ROUTE, SWITCH.
REQ-023 IDLE: in_ready = 0; enable = 1 -> ROUTE next cycle, beat counter = 0, sel = (mode ? force_sel : sel).
REQ-024 ROUTE: each accepted beat increments beat counter; beat stored with dest = sel.
REQ-025 ROUTE: accept of beat number BURST_LEN (counter == BURST_LEN-1) -> burst_done = 1 next cycle, counter = 0, state -> SWITCH.
REQ-026 SWITCH: in_ready = 0; waits until entry empty or draining this cycle; then sel_next = mode ? force_sel : ~sel; state -> ROUTE if enable = 1, else IDLE.
REQ-027 enable deassert mid-burst has no effect; burst always completes at BURST_LEN beats.
REQ-028 mode/force_sel changes take effect only at SWITCH exit or IDLE exit; sel never changes inside a burst.
REQ-029 BURST_LEN = 1: every accepted beat ends a burst; max throughput 1 beat per 2 cycles.
REQ-030 Beat counter width = 8 bits; wraps to 0 only via REQ-025, never by overflow.

Reset
REQ-031 On reset assertion, immediately: state = IDLE, counter = 0, entry empty, out_valid = 2'b00, out_data = 0, sel = 0, in_ready = 0, burst_done = 0.
REQ-032 Reset mid-burst discards the stored beat and partial count; first burst after release starts at beat 0.
REQ-033 Leaving reset, block waits in IDLE at least one cycle before accepting.

Structure
REQ-034 Shared package holds FSM state encoding (IDLE=2'd0, ROUTE=2'd1, SWITCH=2'd2) and defaults for DATA_WIDTH and BURST_LEN.
REQ-035 Destination decode instantiates the existing 1-to-2 demultiplexer as the one sub-module: input = entry-full, select = dest_q, output = out_valid.

Verification
REQ-036 Round-robin, BURST_LEN=4, enable=1, in_valid=1 continuous, out_ready=2'b11, data 0x01..0x08 -> 0x01-0x04 on dest 0, 0x05-0x08 on dest 1, burst_done after beats 4 and 8, one bubble per SWITCH.
REQ-037 Forced, force_sel=1, 8 beats -> all beats on dest 1, sel stays 1; force_sel toggled mid-burst -> change applied only at next burst.
REQ-038 Backpressure: out_ready[0]=0 for 3 cycles during burst to dest 0 -> in_ready=0, out_data stable, no beat lost/duplicated; out_ready[1] toggling ignored.
REQ-039 Reset asserted asynchronously after beat 2 of burst -> outputs reach REQ-031 values without clock edge; next burst starts at dest 0, beat counter 0.
REQ-040 BURST_LEN=1 and enable deasserted after burst 1 -> dest alternates 0,1 per beat, then state IDLE, in_ready=0, no further out_valid.

Source files
------------

// File: rtl/demux_burst_scheduler_pkg.sv
// Shared definitions for the burst demultiplexing scheduler: FSM state
// encoding, parameter defaults and the destination-selection helper.
package demux_burst_scheduler_pkg;

  // Default data path width and beats per burst.
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_BURST_LEN  = 4;

  // The beat counter is a fixed 8 bits wide, enough for bursts up to 255 beats.
  localparam int CNT_WIDTH = 8;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  // Destination for the next burst. Forced mode takes the requested
  // destination. Round-robin mode takes the supplied alternative.
  function automatic logic burst_dest(input logic mode,
                                      input logic force_sel,
                                      input logic alt);
    return mode ? force_sel : alt;
  endfunction

endpackage

// File: rtl/demux_burst_scheduler_demux.sv
// Existing 1-to-2 demultiplexer. It steers a single strobe onto one of two
// outputs. The unselected output is held low.
module demux_burst_scheduler_demux (
  input  logic       din,
  input  logic       sel,
  output logic [1:0] dout
);

  assign dout = sel ? {din, 1'b0} : {1'b0, din};

endmodule

// File: rtl/demux_burst_scheduler.sv
// Burst demultiplexing scheduler. Beats from one source are sent to one of two
// destinations in bursts of BURST_LEN beats. The destination changes only
// between bursts, either by round-robin or by a forced selection. Each beat
// passes through a one-entry output register. The entry can drain and refill
// in the same cycle, so a burst runs at full rate.
module demux_burst_scheduler
  import demux_burst_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BURST_LEN  = DEFAULT_BURST_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  input  logic                  force_sel,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [1:0]            out_ready,
  output logic [1:0]            out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  sel,
  output logic                  burst_done
);

  // Counter value at which the accepted beat closes the burst.
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   sel_q, sel_d;
  logic                   burst_done_q;
  logic                   last_accept;

  // One-entry output register: occupancy, destination tag and payload.
  logic                   full_q;
  logic                   dest_q;
  logic [DATA_WIDTH-1:0]  data_q;

  logic                   accept;
  logic                   drain;

  // The entry empties when its addressed destination takes it. The ready
  // input of the other destination is never consulted.
  assign drain    = full_q & out_ready[dest_q];
  assign in_ready = (state_q == ROUTE) & (~full_q | out_ready[dest_q]);
  assign accept   = in_valid & in_ready;

  // Next-state logic: burst sequencing and destination choice between bursts.
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    last_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ROUTE;
          cnt_d   = '0;
          sel_d   = burst_dest(mode, force_sel, sel_q);
        end
      end
      ROUTE: begin
        if (accept) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d       = '0;
            state_d     = SWITCH;
            last_accept = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      SWITCH: begin
        // Hold the old destination until the final beat has left the entry.
        if (!full_q || drain) begin
          sel_d   = burst_dest(mode, force_sel, ~sel_q);
          state_d = enable ? ROUTE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, beat counter, current destination and the burst-end pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so all of these
      // registers update together from values taken before the edge.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      burst_done_q <= last_accept;
    end
  end

  // Output entry: an accept refills the entry, otherwise a drain empties it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      dest_q <= 1'b0;
      // NOTE: the payload register is reset as well, because out_data must
      // read zero while reset is asserted.
      data_q <= '0;
    end else if (accept) begin
      full_q <= 1'b1;
      dest_q <= sel_q;
      data_q <= in_data;
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end

  // The demultiplexer maps entry occupancy onto the tagged destination's valid.
  demux_burst_scheduler_demux u_demux (
    .din  (full_q),
    .sel  (dest_q),
    .dout (out_valid)
  );

  assign out_data   = data_q;
  assign sel        = sel_q;
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_demux_burst_scheduler.sv
// Directed self-checking bench for demux_burst_scheduler. One instance uses
// BURST_LEN=4 and a second uses BURST_LEN=1. Both share the clock and reset.
module tb_demux_burst_scheduler;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;

  // BURST_LEN = 4 instance.
  logic          enable, mode, force_sel, in_valid, in_ready, sel, burst_done;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    out_ready, out_valid;

  // BURST_LEN = 1 instance.
  logic          b_enable, b_mode, b_force_sel, b_in_valid, b_in_ready, b_sel, b_burst_done;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_out_ready, b_out_valid;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected values for the round-robin run, one entry per edge E2..E11.
  localparam logic [1:0] S1_OV  [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                         2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
  localparam logic [7:0] S1_OD  [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04,
                                         8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
  localparam logic       S1_BD  [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
  localparam logic       S1_RDY [10] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
  localparam logic       S1_SEL [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0};

  // Expected values for the forced-mode run, one entry per edge E2..E12.
  localparam logic [1:0] S2_OV  [11] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10,
                                         2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
  localparam logic [7:0] S2_OD  [11] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h14, 8'h15,
                                         8'h16, 8'h17, 8'h18, 8'h18, 8'h19};
  localparam logic       S2_SEL [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};

  demux_burst_scheduler #(.DATA_WIDTH(DW), .BURST_LEN(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .force_sel  (force_sel),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .sel        (sel),
    .burst_done (burst_done)
  );

  demux_burst_scheduler #(.DATA_WIDTH(DW), .BURST_LEN(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .enable     (b_enable),
    .mode       (b_mode),
    .force_sel  (b_force_sel),
    .in_valid   (b_in_valid),
    .in_data    (b_in_data),
    .in_ready   (b_in_ready),
    .out_ready  (b_out_ready),
    .out_valid  (b_out_valid),
    .out_data   (b_out_data),
    .sel        (b_sel),
    .burst_done (b_burst_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One cycle of the source. The next beat is presented only after the
  // current one has been accepted.
  task automatic step();
    logic acc;
    #1;
    acc = in_valid & in_ready;
    tick();
    if (acc) in_data = in_data + 8'd1;
  endtask

  // Hold reset for two edges with both sources idle, then release it.
  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b0; mode   = 1'b0; force_sel   = 1'b0; in_valid   = 1'b0;
    in_data     = '0;   out_ready   = 2'b11;
    b_enable    = 1'b0; b_mode = 1'b0; b_force_sel = 1'b0; b_in_valid = 1'b0;
    b_in_data   = '0;   b_out_ready = 2'b11;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // ---------------- reset values ----------------
    reset = 1'b1;
    enable = 1'b0; mode = 1'b0; force_sel = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 2'b11;
    b_enable = 1'b0; b_mode = 1'b0; b_force_sel = 1'b0; b_in_valid = 1'b0;
    b_in_data = '0; b_out_ready = 2'b11;
    tick();
    enable = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    tick();
    check("rst_out_valid",  out_valid,  2'b00);
    check("rst_out_data",   out_data,   8'h00);
    check("rst_sel",        sel,        1'b0);
    check("rst_in_ready",   in_ready,   1'b0);
    check("rst_burst_done", burst_done, 1'b0);

    // ---------------- round-robin, continuous traffic ----------------
    do_reset();
    enable = 1'b1; mode = 1'b0; in_valid = 1'b1; in_data = 8'h01; out_ready = 2'b11;
    #1;
    check("rr_idle_in_ready", in_ready, 1'b0);
    step();
    check("rr_route_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step();
      if (in_data == 8'h09) in_valid = 1'b0;
      check($sformatf("rr_out_valid_%0d", k), out_valid, S1_OV[k]);
      check($sformatf("rr_out_data_%0d", k),  out_data,  S1_OD[k]);
      check($sformatf("rr_burst_done_%0d", k), burst_done, S1_BD[k]);
      check($sformatf("rr_in_ready_%0d", k),  in_ready,  S1_RDY[k]);
      check($sformatf("rr_sel_%0d", k),       sel,       S1_SEL[k]);
    end

    // ---------------- forced mode, force_sel change mid-burst ----------------
    do_reset();
    enable = 1'b1; mode = 1'b1; force_sel = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    step();
    check("fo_sel_first", sel, 1'b1);
    for (int k = 0; k < 11; k++) begin
      step();
      if (in_data == 8'h17) force_sel = 1'b0;
      check($sformatf("fo_out_valid_%0d", k), out_valid, S2_OV[k]);
      check($sformatf("fo_out_data_%0d", k),  out_data,  S2_OD[k]);
      check($sformatf("fo_sel_%0d", k),       sel,       S2_SEL[k]);
    end

    // ---------------- backpressure on destination 0 ----------------
    do_reset();
    enable = 1'b1; mode = 1'b0; in_valid = 1'b1; in_data = 8'h21; out_ready = 2'b11;
    step();
    step();
    step();
    check("bp_pre_data", out_data, 8'h22);
    out_ready = 2'b10;
    #1;
    check("bp_stall_rdy_0", in_ready, 1'b0);
    step();
    check("bp_hold_valid_0", out_valid, 2'b01);
    check("bp_hold_data_0",  out_data,  8'h22);
    out_ready = 2'b00;
    #1;
    check("bp_stall_rdy_1", in_ready, 1'b0);
    step();
    check("bp_hold_valid_1", out_valid, 2'b01);
    check("bp_hold_data_1",  out_data,  8'h22);
    out_ready = 2'b10;
    #1;
    check("bp_stall_rdy_2", in_ready, 1'b0);
    step();
    check("bp_hold_valid_2", out_valid, 2'b01);
    check("bp_hold_data_2",  out_data,  8'h22);
    out_ready = 2'b11;
    #1;
    check("bp_resume_rdy", in_ready, 1'b1);
    step();
    check("bp_beat3_data", out_data,   8'h23);
    check("bp_beat3_done", burst_done, 1'b0);
    step();
    check("bp_beat4_data",  out_data,   8'h24);
    check("bp_beat4_done",  burst_done, 1'b1);
    check("bp_switch_rdy",  in_ready,   1'b0);

    // ---------------- asynchronous reset mid-burst ----------------
    do_reset();
    enable = 1'b1; mode = 1'b0; in_valid = 1'b1; in_data = 8'h31; out_ready = 2'b11;
    for (int k = 0; k < 8; k++) step();
    check("ar_pre_valid", out_valid, 2'b10);
    check("ar_pre_data",  out_data,  8'h36);
    check("ar_pre_sel",   sel,       1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("ar_out_valid",  out_valid,  2'b00);
    check("ar_out_data",   out_data,   8'h00);
    check("ar_sel",        sel,        1'b0);
    check("ar_in_ready",   in_ready,   1'b0);
    check("ar_burst_done", burst_done, 1'b0);
    tick();
    reset = 1'b0;
    in_data = 8'h41;
    #1;
    check("ar_release_idle_rdy", in_ready, 1'b0);
    step();
    check("ar_restart_sel", sel,      1'b0);
    check("ar_restart_rdy", in_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("ar_burst_done_%0d", k), burst_done, (k == 3) ? 1'b1 : 1'b0);
      check($sformatf("ar_out_valid_%0d", k),  out_valid,  2'b01);
    end
    check("ar_last_data", out_data, 8'h44);

    // ---------------- BURST_LEN = 1, enable dropped after second burst ----------------
    do_reset();
    b_enable = 1'b1; b_mode = 1'b0; b_in_valid = 1'b1; b_in_data = 8'h51; b_out_ready = 2'b11;
    tick();
    check("bl1_route_rdy", b_in_ready, 1'b1);
    tick();
    b_in_data = 8'h52;
    check("bl1_b0_valid", b_out_valid,  2'b01);
    check("bl1_b0_data",  b_out_data,   8'h51);
    check("bl1_b0_done",  b_burst_done, 1'b1);
    check("bl1_b0_rdy",   b_in_ready,   1'b0);
    tick();
    check("bl1_gap_valid", b_out_valid, 2'b00);
    check("bl1_gap_rdy",   b_in_ready,  1'b1);
    check("bl1_gap_sel",   b_sel,       1'b1);
    tick();
    b_enable = 1'b0;
    check("bl1_b1_valid", b_out_valid,  2'b10);
    check("bl1_b1_data",  b_out_data,   8'h52);
    check("bl1_b1_done",  b_burst_done, 1'b1);
    check("bl1_b1_rdy",   b_in_ready,   1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bl1_idle_valid_%0d", k), b_out_valid,  2'b00);
      check($sformatf("bl1_idle_rdy_%0d", k),   b_in_ready,   1'b0);
      check($sformatf("bl1_idle_done_%0d", k),  b_burst_done, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
